// File: rtl/multicycle_control_unit.sv
// Multi-cycle LEGv8 control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory handshake and timeout.
// Optional CBNZ decode and branch_nz output are enabled by defining CU_CBNZ_EN.
module multicycle_control_unit #(
  parameter int unsigned OPCODE_W    = 11,
  parameter int unsigned ALUOP_W     = 2,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] instr_in,
  input  logic                instr_valid,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                ir_write,
  output logic                reg2Loc,
  output logic                ALUsrc,
  output logic                memtoReg,
  output logic                regWrite,
  output logic                memRead,
  output logic                memWrite,
  output logic                branch,
  output logic                uncond_branch,
  output logic [ALUOP_W-1:0]  ALUop,
  output logic                illegal_op,
  output logic                mem_err,
`ifdef CU_CBNZ_EN
  output logic                branch_nz,
`endif
  output logic [2:0]          state
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    CL_ILL, CL_LDUR, CL_STUR, CL_RTYPE, CL_ITYPE, CL_CBZ, CL_CBNZ, CL_B
  } class_t;

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] opcode_q;
  logic [CNT_W-1:0]    cnt_q;
  class_t              op_class;
  logic                mem_timeout;

  // Instruction class decoded from the latched opcode
  always_comb begin
    op_class = CL_ILL;
    casez (opcode_q)
      11'b11111000010: op_class = CL_LDUR;
      11'b11111000000: op_class = CL_STUR;
      11'b10001011000,
      11'b11001011000,
      11'b10001010000,
      11'b10101010000: op_class = CL_RTYPE;
      11'b1001000100?,
      11'b1101000100?: op_class = CL_ITYPE;
      11'b10110100???: op_class = CL_CBZ;
`ifdef CU_CBNZ_EN
      11'b10110101???: op_class = CL_CBNZ;
`endif
      11'b000101?????: op_class = CL_B;
      default:         op_class = CL_ILL;
    endcase
  end

  // Timeout fires on the MEM_TIMEOUT-th cycle without mem_ready; mem_ready takes priority
  assign mem_timeout = (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) && !mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (state_q == FETCH && instr_valid) opcode_q <= instr_in;
      cnt_q <= (state_q == MEM && !mem_ready) ? cnt_q + CNT_W'(1) : '0;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    reg2Loc       = 1'b0;
    ALUsrc        = 1'b0;
    memtoReg      = 1'b0;
    regWrite      = 1'b0;
    memRead       = 1'b0;
    memWrite      = 1'b0;
    branch        = 1'b0;
    uncond_branch = 1'b0;
    ALUop         = '0;
    illegal_op    = 1'b0;
    mem_err       = 1'b0;

    case (state_q)
      FETCH: if (instr_valid) state_d = DECODE;
      DECODE: begin
        if (op_class == CL_ILL) begin
          illegal_op = 1'b1;
          pc_write   = 1'b1;
          state_d    = FETCH;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        case (op_class)
          CL_RTYPE, CL_ITYPE: state_d = WB;
          CL_LDUR, CL_STUR:   state_d = MEM;
          CL_CBZ, CL_CBNZ: begin
            branch   = 1'b1;
            pc_write = 1'b1;
            state_d  = FETCH;
          end
          CL_B: begin
            uncond_branch = 1'b1;
            pc_write      = 1'b1;
            state_d       = FETCH;
          end
          default: state_d = FETCH;
        endcase
      end
      MEM: begin
        memRead  = (op_class == CL_LDUR);
        memWrite = (op_class == CL_STUR);
        if (mem_ready) begin
          if (op_class == CL_LDUR) begin
            state_d = WB;
          end else begin
            pc_write = 1'b1;
            state_d  = FETCH;
          end
        end else if (mem_timeout) begin
          mem_err  = 1'b1;
          pc_write = 1'b1;
          state_d  = FETCH;
        end
      end
      WB: begin
        regWrite = 1'b1;
        memtoReg = (op_class == CL_LDUR);
        pc_write = 1'b1;
        state_d  = FETCH;
      end
      default: state_d = FETCH;
    endcase

    // Per-class datapath selects held through EXEC/MEM/WB
    if (state_q == EXEC || state_q == MEM || state_q == WB) begin
      case (op_class)
        CL_LDUR, CL_STUR: begin
          reg2Loc = 1'b1;
          ALUsrc  = 1'b1;
          ALUop   = ALUOP_W'(2'b00);
        end
        CL_RTYPE: ALUop = ALUOP_W'(2'b10);
        CL_ITYPE: begin
          ALUsrc = 1'b1;
          ALUop  = ALUOP_W'(2'b11);
        end
        CL_CBZ, CL_CBNZ: begin
          reg2Loc = 1'b1;
          ALUop   = ALUOP_W'(2'b01);
        end
        CL_B:    ALUop = ALUOP_W'(2'b01);
        default: ALUop = '0;
      endcase
    end
  end

`ifdef CU_CBNZ_EN
  assign branch_nz = (state_q == EXEC) && (op_class == CL_CBNZ);
`endif

  assign ir_write = (state_q == FETCH) && instr_valid && rst_n;
  assign state    = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: per-cycle output traces from a spec-level model.
module tb_multicycle_control_unit;

  localparam int unsigned TIMEOUT = 15;

  localparam int C_ILL   = 0;
  localparam int C_LDUR  = 1;
  localparam int C_STUR  = 2;
  localparam int C_RTYPE = 3;
  localparam int C_ITYPE = 4;
  localparam int C_CBZ   = 5;
  localparam int C_CBNZ  = 6;
  localparam int C_B     = 7;

  typedef struct packed {
    logic [2:0] st;
    logic       pc_write;
    logic       ir_write;
    logic       reg2loc;
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       ubranch;
    logic [1:0] aluop;
    logic       illegal;
    logic       merr;
    logic       bnz;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] instr_in;
  logic        instr_valid;
  logic        mem_ready;
  logic        pc_write, ir_write, reg2Loc, ALUsrc, memtoReg, regWrite;
  logic        memRead, memWrite, branch, uncond_branch, illegal_op, mem_err;
  logic [1:0]  ALUop;
  logic [2:0]  state;
`ifdef CU_CBNZ_EN
  logic        branch_nz;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multicycle_control_unit #(
    .OPCODE_W(11), .ALUOP_W(2), .MEM_TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .instr_valid(instr_valid),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .reg2Loc(reg2Loc), .ALUsrc(ALUsrc), .memtoReg(memtoReg), .regWrite(regWrite),
    .memRead(memRead), .memWrite(memWrite), .branch(branch),
    .uncond_branch(uncond_branch), .ALUop(ALUop), .illegal_op(illegal_op),
    .mem_err(mem_err),
`ifdef CU_CBNZ_EN
    .branch_nz(branch_nz),
`endif
    .state(state)
  );

  function automatic obs_t sample();
    obs_t o;
    o = '{st: state, pc_write: pc_write, ir_write: ir_write, reg2loc: reg2Loc,
          alusrc: ALUsrc, memtoreg: memtoReg, regwrite: regWrite, memread: memRead,
          memwrite: memWrite, branch: branch, ubranch: uncond_branch, aluop: ALUop,
          illegal: illegal_op, merr: mem_err, bnz: 1'b0};
`ifdef CU_CBNZ_EN
    o.bnz = branch_nz;
`endif
    return o;
  endfunction

  function automatic int classify(input logic [10:0] op);
    if (op == 11'b11111000010) return C_LDUR;
    if (op == 11'b11111000000) return C_STUR;
    if (op == 11'b10001011000 || op == 11'b11001011000 ||
        op == 11'b10001010000 || op == 11'b10101010000) return C_RTYPE;
    if (op[10:1] == 10'b1001000100 || op[10:1] == 10'b1101000100) return C_ITYPE;
    if (op[10:3] == 8'b10110100) return C_CBZ;
`ifdef CU_CBNZ_EN
    if (op[10:3] == 8'b10110101) return C_CBNZ;
`endif
    if (op[10:5] == 6'b000101) return C_B;
    return C_ILL;
  endfunction

  // Class-wide selects while the instruction is past DECODE
  function automatic obs_t ctl(input int cls, input logic [2:0] st);
    obs_t e;
    e = '0;
    e.st = st;
    if (cls == C_LDUR || cls == C_STUR) begin e.reg2loc = 1; e.alusrc = 1; e.aluop = 2'd0; end
    if (cls == C_RTYPE) e.aluop = 2'd2;
    if (cls == C_ITYPE) begin e.alusrc = 1; e.aluop = 2'd3; end
    if (cls == C_CBZ || cls == C_CBNZ) begin e.reg2loc = 1; e.aluop = 2'd1; end
    if (cls == C_B) e.aluop = 2'd1;
    return e;
  endfunction

  // Runs one instruction from FETCH; waits = mem_ready=0 cycles before ready (>= TIMEOUT never ready)
  task automatic run_instr(input logic [10:0] op, input int waits, input string name);
    obs_t q[$];
    obs_t e, o;
    int   cls, n_mem;
    bit   is_mem;
    cls    = classify(op);
    is_mem = (cls == C_LDUR || cls == C_STUR);
    e = '0; e.ir_write = 1; q.push_back(e);
    e = '0; e.st = 3'd1;
    if (cls == C_ILL) begin e.illegal = 1; e.pc_write = 1; end
    q.push_back(e);
    if (cls != C_ILL) begin
      e = ctl(cls, 3'd2);
      if (cls == C_CBZ || cls == C_CBNZ) begin e.branch = 1; e.pc_write = 1; end
      if (cls == C_CBNZ) e.bnz = 1;
      if (cls == C_B) begin e.ubranch = 1; e.pc_write = 1; end
      q.push_back(e);
      if (is_mem) begin
        n_mem = (waits < int'(TIMEOUT)) ? waits + 1 : int'(TIMEOUT);
        for (int i = 0; i < n_mem; i++) begin
          e = ctl(cls, 3'd3);
          e.memread  = (cls == C_LDUR);
          e.memwrite = (cls == C_STUR);
          if (i == waits) begin
            if (cls == C_STUR) e.pc_write = 1;
          end else if (i == int'(TIMEOUT) - 1) begin
            e.merr = 1; e.pc_write = 1;
          end
          q.push_back(e);
        end
      end
      if (cls == C_RTYPE || cls == C_ITYPE || (cls == C_LDUR && waits < int'(TIMEOUT))) begin
        e = ctl(cls, 3'd4);
        e.regwrite = 1; e.pc_write = 1; e.memtoreg = (cls == C_LDUR);
        q.push_back(e);
      end
    end
    for (int idx = 0; idx < q.size(); idx++) begin
      @(negedge clk);
      instr_valid = (idx == 0) ? 1'b1 : 1'($urandom);
      instr_in    = (idx == 0) ? op : 11'($urandom);
      if (is_mem && idx >= 3 && idx <= 3 + waits) mem_ready = (idx == 3 + waits);
      else mem_ready = 1'($urandom);
      #1;
      o = sample();
      n_tests++;
      if (o !== q[idx]) begin
        n_fail++;
        $display("FAIL %s op=%b cyc=%0d got=%h exp=%h", name, op, idx, o, q[idx]);
      end
    end
  endtask

  task automatic test_reset();
    obs_t o;
    rst_n = 1'b0; instr_valid = 1'b1; instr_in = 11'b10001011000; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      o = sample();
      n_tests++;
      if (o !== obs_t'('0)) begin
        n_fail++; $display("FAIL reset_hold cyc=%0d got=%h exp=0", i, o);
      end
    end
    @(negedge clk);
    rst_n = 1'b1; instr_valid = 1'b0;
  endtask

  task automatic test_idle();
    obs_t o;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      instr_valid = 1'b0; instr_in = 11'($urandom); mem_ready = 1'($urandom);
      #1;
      o = sample();
      n_tests++;
      if (o !== obs_t'('0)) begin
        n_fail++; $display("FAIL idle cyc=%0d got=%h exp=0", i, o);
      end
    end
  endtask

  task automatic test_reset_mid_mem();
    obs_t o;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      instr_valid = (i == 0); instr_in = 11'b11111000010; mem_ready = 1'b0;
    end
    #1;
    n_tests++;
    if (state !== 3'd3 || memRead !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_mem got state=%0d memRead=%b exp 3/1", state, memRead);
    end
    rst_n = 1'b0; instr_valid = 1'b1;
    #1;
    o = sample();
    n_tests++;
    if (o !== obs_t'('0)) begin
      n_fail++; $display("FAIL reset_async got=%h exp=0", o);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      o = sample();
      n_tests++;
      if (o !== obs_t'('0)) begin
        n_fail++; $display("FAIL reset_mid_hold cyc=%0d got=%h exp=0", i, o);
      end
    end
    @(negedge clk);
    rst_n = 1'b1; instr_valid = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      o = sample();
      n_tests++;
      if (o !== obs_t'('0)) begin
        n_fail++; $display("FAIL reset_release cyc=%0d got=%h exp=0", i, o);
      end
    end
  endtask

  task automatic test_directed();
    run_instr(11'b10001011000, 0, "add");
    run_instr(11'b11111000010, 3, "ldur_wait3");
    run_instr(11'b11111000000, 1000, "stur_timeout");
    run_instr(11'b11111000010, 1000, "ldur_timeout");
    run_instr(11'b11111000000, int'(TIMEOUT) - 1, "stur_ready_at_timeout");
    run_instr(11'b00010100000, 0, "b");
    run_instr(11'b10110100111, 0, "cbz");
    run_instr(11'b11111111111, 0, "illegal");
    run_instr(11'b10110101000, 0, "cbnz_or_illegal");
    run_instr(11'b10010001001, 0, "addi");
    run_instr(11'b11010001000, 0, "subi");
  endtask

  task automatic test_back_to_back();
    logic [10:0] op;
    int          waits;
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 9))
        0: op = 11'b11111000010;
        1: op = 11'b11111000000;
        2: begin
          case ($urandom_range(0, 3))
            0: op = 11'b10001011000;
            1: op = 11'b11001011000;
            2: op = 11'b10001010000;
            default: op = 11'b10101010000;
          endcase
        end
        3: op = {10'b1001000100, 1'($urandom)};
        4: op = {10'b1101000100, 1'($urandom)};
        5: op = {8'b10110100, 3'($urandom)};
        6: op = {6'b000101, 5'($urandom)};
        7: op = {8'b10110101, 3'($urandom)};
        default: op = 11'($urandom);
      endcase
      waits = int'($urandom_range(0, 18));
      run_instr(op, waits, "random");
    end
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr_in = '0; mem_ready = 1'b0;
    test_reset();
    test_idle();
    test_directed();
    test_reset_mid_mem();
    test_back_to_back();
    test_idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
